data_sram_responder: RTL and testbench
======================================

DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 SHALL have parameter AW, default 14, giving the RAM word-address width.
REQ-002 SHALL have parameter DELAY, default 0, range 0..7, giving the extra wait cycles before each data_data_ok.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port data_req, input, 1: CPU request valid.
REQ-006 SHALL have port data_wr, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port data_size, input, 2: 0 = byte, 1 = half, 2 = word; 3 is reserved and is treated as word.
REQ-008 SHALL have port data_addr, input, 32: byte address.
REQ-009 SHALL have port data_wdata, input, 32: store data, already lane-aligned by the CPU.
REQ-010 SHALL have port data_addr_ok, output, 1: request accepted this cycle if data_req is also high.
REQ-011 SHALL have port data_data_ok, output, 1: one-cycle response pulse.
REQ-012 SHALL have port data_rdata, output, 32: load data, valid while data_data_ok is high.
REQ-013 SHALL have port ram_en, output, 1: synchronous RAM enable.
REQ-014 SHALL have port ram_wen, output, 4: byte write enables.
REQ-015 SHALL have port ram_addr, output, AW: word address, equal to data_addr[AW+1:2].
REQ-016 SHALL have port ram_wdata, output, 32: equal to data_wdata.
REQ-017 SHALL have port ram_rdata, input, 32: RAM read data, valid one cycle after ram_en.

Function
REQ-018 SHALL define acceptance as data_req && data_addr_ok in cycle T.
REQ-019 SHALL drive data_addr_ok = (outstanding count < 2); this is registered state only, with no combinational dependence on data_req or data_data_ok.
REQ-020 SHALL drive ram_en combinationally equal to acceptance, and SHALL hold ram_wen at 0 unless acceptance occurs with data_wr = 1.
REQ-021 SHALL set ram_wen as follows:
- byte: 4'b0001 << addr[1:0]
- half: addr[1] ? 4'b1100 : 4'b0011
- word or size 3: 4'b1111
REQ-022 SHALL allocate a 2-entry in-order response FIFO slot at acceptance, recording wr; the outstanding count SHALL increment at acceptance.
REQ-023 SHALL capture ram_rdata into the slot at the end of cycle T+1 for loads; stores SHALL record rdata = 0.
REQ-024 SHALL maintain a 3-bit wait counter for the head slot: it starts at 0 once the head is filled, increments each cycle while below DELAY, and clears on data_data_ok.
REQ-025 SHALL assert data_data_ok for exactly one cycle when the head is filled and the wait counter equals DELAY; the first response SHALL therefore appear in cycle T+2+DELAY.
REQ-026 SHALL drive data_rdata from the head slot whenever data_data_ok is high, and 0 otherwise.
REQ-027 SHALL pop the head and decrement the count on data_data_ok; no backpressure exists, and the CPU always takes the pulse.
REQ-028 SHALL leave the count unchanged when acceptance and data_data_ok occur in the same cycle, with both the push and the pop performed.
REQ-029 SHALL give back-to-back requests accepted in T and T+1 with DELAY = 0 responses in T+2 and T+3.
REQ-030 SHALL return responses strictly in acceptance order, mixing loads and stores.
REQ-031 SHALL wrap the FIFO pointers (1 bit each) modulo 2 with no loss.
REQ-032 SHALL keep data_addr_ok low at count = 2 so that data_req is ignored; no slot is overwritten.
REQ-033 SHALL ignore data_size and data_addr[1:0] on loads; the CPU selects the byte lanes itself.

Reset
REQ-034 SHALL clear on reset: count = 0, both pointers = 0, slot valid and filled flags = 0, wait counter = 0.
REQ-035 SHALL drive data_data_ok = 0 and data_rdata = 0 in the reset cycle.
REQ-036 SHALL have data_addr_ok = 1 from the first cycle after reset.
REQ-037 SHALL drive ram_en = 0 and ram_wen = 0 in the reset cycle regardless of data_req.
REQ-038 SHALL discard all outstanding requests when reset occurs mid-operation; no data_data_ok SHALL appear for them afterwards, and RAM contents are untouched.

Structure
REQ-039 SHALL place the data_size encodings (BYTE/HALF/WORD) and the FIFO depth constant (2) in the shared mycpu.h header.
REQ-040 SHALL use one natural sub-module, resp_fifo (2-entry, {wr, rdata}, push/fill/pop); the wait counter and strobe decode stay in the top.

Verification
REQ-041 SHALL cover: store word addr 0x10, wdata 0xAABBCCDD, then load addr 0x10, DELAY = 0 -> ram_wen = 1111 at accept; load data_data_ok 2 cycles after its accept with rdata 0xAABBCCDD.
REQ-042 SHALL cover: byte store addr 0x13 and half store addr 0x22 -> ram_wen = 1000 and 1100, with ram_addr = 0x4 and 0x8.
REQ-043 SHALL cover: three consecutive data_req cycles with data_data_ok pending -> addr_ok high for 2 cycles then low; the third is accepted only after the first data_data_ok, and responses come in order.
REQ-044 SHALL cover: DELAY = 3, single load accepted in cycle 5 -> data_data_ok exactly in cycle 10, high for 1 cycle.
REQ-045 SHALL cover: accept and data_data_ok in the same cycle at count 1 -> count stays 1, and data_addr_ok stays high next cycle.
REQ-046 SHALL cover: reset asserted with 2 loads outstanding -> no data_data_ok within 10 cycles after deassert, and data_addr_ok = 1 the cycle after reset.

Source files
------------

// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-side SRAM responder: size encodings, FIFO depth, slot record.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package data_sram_responder_pkg;

    // CPU access size encoding on data_size; the reserved code behaves like a word.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    // Number of requests that may be in flight at once.
    localparam int FIFO_DEPTH = 2;

    // One in-order response slot: was it a store, and the data to return.
    typedef struct packed {
        logic        wr;
        logic [31:0] rdata;
    } resp_t;

    // Byte-lane write enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] strb;
        case (size_e'(size))
            SIZE_BYTE: strb = 4'b0001 << off;
            SIZE_HALF: strb = off[1] ? 4'b1100 : 4'b0011;
            default:   strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/data_sram_responder_resp_fifo.sv
// Two-entry in-order response queue: push allocates a slot, fill stores its read data, pop retires the head.
// Latency: a slot is visible as head_filled the cycle after its fill.
// Backpressure: none internally; the owner must not push when count is full.
// Ports: clk/reset; push+push_wr allocate; fill+fill_rdata complete the oldest unfilled slot;
//        pop retires the head; count, head_filled, head_rdata report state.
module resp_fifo
    import data_sram_responder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        push_wr,
    input  logic        fill,
    input  logic [31:0] fill_rdata,
    input  logic        pop,
    output logic [1:0]  count,
    output logic        head_filled,
    output logic [31:0] head_rdata
);

    resp_t      slot [2];
    logic [1:0] vld;
    logic [1:0] filled;
    logic       wptr;
    logic       rptr;
    logic       fptr;   // next slot to receive read data; fills arrive in push order

    always_ff @(posedge clk) begin
        if (reset) begin
            vld    <= 2'b00;
            filled <= 2'b00;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            fptr   <= 1'b0;
            count  <= 2'd0;
            slot[0] <= '0;
            slot[1] <= '0;
        end else begin
            // push, fill and pop always address distinct slots, so the updates never collide
            if (push) begin
                slot[wptr].wr <= push_wr;
                vld[wptr]     <= 1'b1;
                filled[wptr]  <= 1'b0;
                wptr          <= ~wptr;
            end
            if (fill) begin
                slot[fptr].rdata <= slot[fptr].wr ? 32'h0 : fill_rdata;
                filled[fptr]     <= 1'b1;
                fptr             <= ~fptr;
            end
            if (pop) begin
                vld[rptr]    <= 1'b0;
                filled[rptr] <= 1'b0;
                rptr         <= ~rptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_filled = vld[rptr] && filled[rptr];
    assign head_rdata  = slot[rptr].rdata;

endmodule

// File: rtl/data_sram_responder.sv
// SRAM-style CPU data port bridged onto a synchronous single-port RAM with up to two requests in flight.
// Latency: response pulse DELAY+2 cycles after acceptance; back-to-back accepts give back-to-back responses.
// Backpressure: data_addr_ok drops while two requests are outstanding; responses cannot be stalled.
// Ports: clk/reset; data_* CPU request/response side; ram_* synchronous RAM side (read data one cycle after ram_en).
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int AW    = 14,
    parameter int DELAY = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [31:0]   data_addr,
    input  logic [31:0]   data_wdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [31:0]   data_rdata,
    output logic          ram_en,
    output logic [3:0]    ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    logic        accept;
    logic        fill_q;       // a request was accepted last cycle; its RAM data is on ram_rdata now
    logic [2:0]  wait_cnt;
    logic [1:0]  count;
    logic        head_filled;
    logic [31:0] head_rdata;
    logic        unused_addr_hi;

    // Only registered state feeds addr_ok, so the CPU never sees a combinational loop through it.
    assign data_addr_ok = (count < 2'(FIFO_DEPTH));
    assign accept       = data_req && data_addr_ok && !reset;

    assign ram_en    = accept;
    assign ram_wen   = (accept && data_wr) ? byte_strobe(data_size, data_addr[1:0]) : 4'b0000;
    assign ram_addr  = data_addr[AW+1:2];
    assign ram_wdata = data_wdata;

    assign unused_addr_hi = ^data_addr[31:AW+2];

    assign data_data_ok = !reset && head_filled && (wait_cnt == 3'(DELAY));
    assign data_rdata   = data_data_ok ? head_rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_q   <= 1'b0;
            wait_cnt <= 3'd0;
        end else begin
            fill_q <= accept;
            // Counter sits at 0 until the head holds data, then walks up to DELAY.
            if (data_data_ok) begin
                wait_cnt <= 3'd0;
            end else if (head_filled && (wait_cnt != 3'(DELAY))) begin
                wait_cnt <= wait_cnt + 3'd1;
            end
        end
    end

    resp_fifo u_resp_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (accept),
        .push_wr     (data_wr),
        .fill        (fill_q),
        .fill_rdata  (ram_rdata),
        .pop         (data_data_ok),
        .count       (count),
        .head_filled (head_filled),
        .head_rdata  (head_rdata)
    );

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    // second instance with DELAY = 3, driven only during its own test
    logic        d3_req;
    logic [31:0] d3_addr;
    logic        d3_addr_ok;
    logic        d3_data_ok;
    logic [31:0] d3_rdata;
    logic        d3_ram_en;
    logic [3:0]  d3_ram_wen;
    logic [13:0] d3_ram_addr;
    logic [31:0] d3_ram_wdata;
    logic [31:0] d3_ram_rdata;

    logic [31:0] mem0 [64];
    logic [31:0] mem3 [64];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_sram_responder #(.AW(14), .DELAY(0)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .ram_en       (ram_en),
        .ram_wen      (ram_wen),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    data_sram_responder #(.AW(14), .DELAY(3)) dut3 (
        .clk          (clk),
        .reset        (reset),
        .data_req     (d3_req),
        .data_wr      (1'b0),
        .data_size    (2'd2),
        .data_addr    (d3_addr),
        .data_wdata   (32'h0),
        .data_addr_ok (d3_addr_ok),
        .data_data_ok (d3_data_ok),
        .data_rdata   (d3_rdata),
        .ram_en       (d3_ram_en),
        .ram_wen      (d3_ram_wen),
        .ram_addr     (d3_ram_addr),
        .ram_wdata    (d3_ram_wdata),
        .ram_rdata    (d3_ram_rdata)
    );

    // synchronous RAM models: registered read, byte-lane writes
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= mem0[ram_addr[5:0]];
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) mem0[ram_addr[5:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        end
    end

    always @(posedge clk) begin
        if (d3_ram_en) begin
            d3_ram_rdata <= mem3[d3_ram_addr[5:0]];
            for (int b = 0; b < 4; b++)
                if (d3_ram_wen[b]) mem3[d3_ram_addr[5:0]][b*8 +: 8] <= d3_ram_wdata[b*8 +: 8];
        end
    end

    typedef struct {
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        e_aok;
        logic        e_en;
        logic [3:0]  e_wen;
        logic [13:0] e_raddr;
        logic        e_dok;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vt [19];

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%08h expected=0x%08h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        data_req   = req;
        data_wr    = wr;
        data_size  = size;
        data_addr  = addr;
        data_wdata = wdata;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem0[i] = 32'h0;
            mem3[i] = 32'h0;
        end
        mem3[4]      = 32'hCAFEF00D;
        ram_rdata    = 32'h0;
        d3_ram_rdata = 32'h0;
        d3_req       = 1'b0;
        d3_addr      = 32'h0;

        //                req  wr  size   addr          wdata          aok  en  wen      raddr  dok  rdata
        vt[0]  = '{1'b0, 1'b0, 2'd0, 32'h00, 32'h0,        1'b1, 1'b0, 4'h0, 14'd0,  1'b0, 32'h0};
        vt[1]  = '{1'b1, 1'b1, 2'd2, 32'h10, 32'hAABBCCDD, 1'b1, 1'b1, 4'hF, 14'd4,  1'b0, 32'h0};
        vt[2]  = '{1'b1, 1'b0, 2'd2, 32'h10, 32'h0,        1'b1, 1'b1, 4'h0, 14'd4,  1'b0, 32'h0};
        vt[3]  = '{1'b1, 1'b1, 2'd2, 32'h30, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 14'd12, 1'b1, 32'h0};
        vt[4]  = '{1'b0, 1'b0, 2'd0, 32'h00, 32'h0,        1'b1, 1'b0, 4'h0, 14'd0,  1'b1, 32'hAABBCCDD};
        vt[5]  = '{1'b0, 1'b0, 2'd0, 32'h00, 32'h0,        1'b1, 1'b0, 4'h0, 14'd0,  1'b0, 32'h0};
        vt[6]  = '{1'b1, 1'b1, 2'd0, 32'h13, 32'h11000000, 1'b1, 1'b1, 4'h8, 14'd4,  1'b0, 32'h0};
        vt[7]  = '{1'b1, 1'b1, 2'd1, 32'h22, 32'h55660000, 1'b1, 1'b1, 4'hC, 14'd8,  1'b0, 32'h0};
        vt[8]  = '{1'b0, 1'b0, 2'd0, 32'h00, 32'h0,        1'b0, 1'b0, 4'h0, 14'd0,  1'b1, 32'h0};
        vt[9]  = '{1'b1, 1'b0, 2'd0, 32'h11, 32'h0,        1'b1, 1'b1, 4'h0, 14'd4,  1'b1, 32'h0};
        vt[10] = '{1'b1, 1'b0, 2'd2, 32'h20, 32'h0,        1'b1, 1'b1, 4'h0, 14'd8,  1'b0, 32'h0};
        vt[11] = '{1'b1, 1'b1, 2'd2, 32'h30, 32'hFFFFFFFF, 1'b0, 1'b0, 4'h0, 14'd12, 1'b1, 32'h11BBCCDD};
        vt[12] = '{1'b0, 1'b0, 2'd0, 32'h00, 32'h0,        1'b1, 1'b0, 4'h0, 14'd0,  1'b1, 32'h55660000};
        vt[13] = '{1'b0, 1'b0, 2'd0, 32'h00, 32'h0,        1'b1, 1'b0, 4'h0, 14'd0,  1'b0, 32'h0};
        vt[14] = '{1'b1, 1'b1, 2'd3, 32'h02, 32'h12345678, 1'b1, 1'b1, 4'hF, 14'd0,  1'b0, 32'h0};
        vt[15] = '{1'b1, 1'b1, 2'd0, 32'h01, 32'h0000AB00, 1'b1, 1'b1, 4'h2, 14'd0,  1'b0, 32'h0};
        vt[16] = '{1'b1, 1'b0, 2'd2, 32'h10, 32'h0,        1'b0, 1'b0, 4'h0, 14'd4,  1'b1, 32'h0};
        vt[17] = '{1'b0, 1'b0, 2'd0, 32'h00, 32'h0,        1'b1, 1'b0, 4'h0, 14'd0,  1'b1, 32'h0};
        vt[18] = '{1'b0, 1'b0, 2'd0, 32'h00, 32'h0,        1'b1, 1'b0, 4'h0, 14'd0,  1'b0, 32'h0};

        // reset cycle with a store request present: nothing may reach the RAM or the CPU
        reset = 1'b1;
        drive(1'b1, 1'b1, 2'd2, 32'h30, 32'h01020304);
        step();
        #1;
        chk("rst_ram_en",  -1, 32'(ram_en), 32'h0);
        chk("rst_ram_wen", -1, 32'(ram_wen), 32'h0);
        chk("rst_data_ok", -1, 32'(data_data_ok), 32'h0);
        chk("rst_rdata",   -1, data_rdata, 32'h0);
        step();
        reset = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        step();

        // table of single-cycle vectors, applied back to back
        for (int i = 0; i < 19; i++) begin
            drive(vt[i].req, vt[i].wr, vt[i].size, vt[i].addr, vt[i].wdata);
            #1;
            chk("addr_ok",   i, 32'(data_addr_ok), 32'(vt[i].e_aok));
            chk("ram_en",    i, 32'(ram_en),       32'(vt[i].e_en));
            chk("ram_wen",   i, 32'(ram_wen),      32'(vt[i].e_wen));
            chk("ram_addr",  i, 32'(ram_addr),     32'(vt[i].e_raddr));
            chk("ram_wdata", i, ram_wdata,         vt[i].wdata);
            chk("data_ok",   i, 32'(data_data_ok), 32'(vt[i].e_dok));
            chk("rdata",     i, data_rdata,        vt[i].e_rdata);
            step();
        end

        // three loads held on data_req: two accepted, third waits for the first response
        drive(1'b1, 1'b0, 2'd2, 32'h10, 32'h0);
        #1;
        chk("q3_aok0", 0, 32'(data_addr_ok), 32'h1);
        step();
        drive(1'b1, 1'b0, 2'd2, 32'h20, 32'h0);
        #1;
        chk("q3_aok1", 1, 32'(data_addr_ok), 32'h1);
        step();
        drive(1'b1, 1'b0, 2'd2, 32'h00, 32'h0);
        #1;
        chk("q3_aok2",   2, 32'(data_addr_ok), 32'h0);
        chk("q3_en2",    2, 32'(ram_en), 32'h0);
        chk("q3_dok2",   2, 32'(data_data_ok), 32'h1);
        chk("q3_rdata2", 2, data_rdata, 32'h11BBCCDD);
        step();
        #1;
        chk("q3_aok3",   3, 32'(data_addr_ok), 32'h1);
        chk("q3_en3",    3, 32'(ram_en), 32'h1);
        chk("q3_dok3",   3, 32'(data_data_ok), 32'h1);
        chk("q3_rdata3", 3, data_rdata, 32'h55660000);
        step();
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        #1;
        chk("q3_dok4", 4, 32'(data_data_ok), 32'h0);
        chk("q3_aok4", 4, 32'(data_addr_ok), 32'h1);
        step();
        #1;
        chk("q3_dok5",   5, 32'(data_data_ok), 32'h1);
        chk("q3_rdata5", 5, data_rdata, 32'h1234AB78);
        step();
        #1;
        chk("q3_dok6", 6, 32'(data_data_ok), 32'h0);
        step();

        // reset with two loads in flight: their responses must vanish
        drive(1'b1, 1'b0, 2'd2, 32'h10, 32'h0);
        step();
        drive(1'b1, 1'b0, 2'd2, 32'h20, 32'h0);
        step();
        reset = 1'b1;
        drive(1'b1, 1'b1, 2'd2, 32'h30, 32'h99999999);
        #1;
        chk("mid_rst_en",  0, 32'(ram_en), 32'h0);
        chk("mid_rst_wen", 0, 32'(ram_wen), 32'h0);
        chk("mid_rst_dok", 0, 32'(data_data_ok), 32'h0);
        chk("mid_rst_rd",  0, data_rdata, 32'h0);
        step();
        reset = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        #1;
        chk("post_rst_aok", 0, 32'(data_addr_ok), 32'h1);
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("post_rst_dok", c, 32'(data_data_ok), 32'h0);
            step();
        end
        chk("mem_untouched", 12, mem0[12], 32'h0);

        // DELAY = 3: load accepted in cycle 5 responds in cycle 10 only
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        for (int c = 0; c < 15; c++) begin
            d3_req  = (c == 5);
            d3_addr = (c == 5) ? 32'h10 : 32'h0;
            #1;
            if (c == 5) chk("d3_accept", c, 32'(d3_ram_en), 32'h1);
            chk("d3_dok",   c, 32'(d3_data_ok), (c == 10) ? 32'h1 : 32'h0);
            chk("d3_rdata", c, d3_rdata, (c == 10) ? 32'hCAFEF00D : 32'h0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
